// File: rtl/adc_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : adc_capture_ctrl
// Description : Read-domain capture sequencer for the ADC CDC FIFO output.
//               Arms on command, waits for a software or rising level-crossing
//               trigger, then forwards a fixed window of cap_len ADC samples
//               to a ready/valid stream with the final beat marked. Samples
//               that find the output register occupied are dropped and
//               reported through a sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_capture_ctrl #(
    parameter int DATA_W = 16,
    parameter int LEN_W  = 16
) (
    input  logic              rd_clk,
    input  logic              rd_rst_n,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    input  logic              arm,
    input  logic              abort,
    input  logic              sw_trig,
    input  logic              trig_en,
    input  logic [DATA_W-1:0] trig_level,
    input  logic [LEN_W-1:0]  cap_len,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [1:0]        state
);

    localparam logic [LEN_W-1:0] c_len_one  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] c_len_zero = '0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [DATA_W-1:0] r_prev;
    logic              r_prev_valid;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_count;
    logic [DATA_W-1:0] r_m_data;
    logic              r_m_valid;
    logic              r_m_last;
    logic              r_overflow;

    logic              w_out_free;
    logic              w_level_trig;
    logic              w_trig;
    logic              w_is_last;
    logic              w_arm_accept;
    logic              w_sample;
    logic              w_load;
    logic              w_drop;

    // The output register can take a new sample when empty or being drained.
    assign w_out_free   = !r_m_valid || m_ready;

    // Rising crossing: previous sample strictly below, current at or above.
    assign w_level_trig = trig_en && s_valid && r_prev_valid &&
                          ($signed(r_prev) < $signed(trig_level)) &&
                          ($signed(s_data) >= $signed(trig_level));
    assign w_trig       = sw_trig || w_level_trig;

    // Counter starts at zero on every arm, so this also covers cap_len=1 in
    // the trigger cycle.
    assign w_is_last    = (r_count == (r_len - c_len_one));

    assign w_load       = w_sample && w_out_free;
    assign w_drop       = w_sample && !w_out_free;

    // State register.
    always_ff @(posedge rd_clk) begin
        if (!rd_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode plus arm acceptance and counted-sample strobes.
    always_comb begin
        w_state_next = r_state;
        w_arm_accept = 1'b0;
        w_sample     = 1'b0;
        if (abort) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (arm && (cap_len != c_len_zero)) begin
                        w_arm_accept = 1'b1;
                        w_state_next = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (w_trig) begin
                        w_state_next = ST_CAPTURE;
                        w_sample     = s_valid;
                        if (s_valid && w_is_last) begin
                            w_state_next = ST_DONE;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (s_valid) begin
                        w_sample = 1'b1;
                        if (w_is_last) begin
                            w_state_next = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    // Re-arm only once the pending beat can no longer be lost.
                    if (arm && (cap_len != c_len_zero) && w_out_free) begin
                        w_arm_accept = 1'b1;
                        w_state_next = ST_ARMED;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Capture length, sample counter and previous-sample tracking.
    always_ff @(posedge rd_clk) begin
        if (!rd_rst_n) begin
            r_len        <= c_len_zero;
            r_count      <= c_len_zero;
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
        end else if (abort) begin
            r_count      <= c_len_zero;
        end else begin
            if (w_arm_accept) begin
                r_len        <= cap_len;
                r_count      <= c_len_zero;
                r_prev_valid <= 1'b0;
            end
            if ((r_state == ST_ARMED) && s_valid) begin
                r_prev       <= s_data;
                r_prev_valid <= 1'b1;
            end
            if (w_sample) begin
                r_count <= w_is_last ? c_len_zero : (r_count + c_len_one);
            end
        end
    end

    // Sticky overflow: set on any dropped sample, cleared only by a new arm.
    always_ff @(posedge rd_clk) begin
        if (!rd_rst_n) begin
            r_overflow <= 1'b0;
        end else if (!abort) begin
            if (w_arm_accept) begin
                r_overflow <= 1'b0;
            end else if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Output register: load on a free slot, otherwise hold until accepted.
    always_ff @(posedge rd_clk) begin
        if (!rd_rst_n) begin
            r_m_data  <= '0;
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
        end else if (abort) begin
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
        end else if (w_load) begin
            r_m_data  <= s_data;
            r_m_valid <= 1'b1;
            r_m_last  <= w_is_last;
        end else if (m_ready) begin
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
        end
    end

    assign m_data   = r_m_data;
    assign m_valid  = r_m_valid;
    assign m_last   = r_m_last;
    assign overflow = r_overflow;
    assign busy     = (r_state == ST_ARMED) || (r_state == ST_CAPTURE);
    assign done     = (r_state == ST_DONE);
    assign state    = r_state;

endmodule
`default_nettype wire

// File: doc/adc_capture_ctrl.md
Name: adc_capture_ctrl

Overview:
Read-domain capture sequencer for the ADC sample stream leaving the ADC CDC FIFO. It arms on command and waits for a software or level-crossing trigger. It then forwards exactly cap_len consecutive samples to a downstream ready/valid stream, marking the final beat. The CDC output has no backpressure, so samples that arrive while the output register is still occupied are dropped and flagged.

Parameters:
DATA_W, 16, sample width; matches the CDC FIFO dout width.
LEN_W, 16, width of the capture length and sample counter.

Ports:
rd_clk  in  1  read-domain clock; all logic is on this edge.
rd_rst_n  in  1  synchronous, active-low reset.
s_data  in  DATA_W  sample from the CDC FIFO dout; two's complement.
s_valid  in  1  sample strobe from the CDC FIFO dout_valid; no backpressure.
arm  in  1  single-cycle pulse to start a capture sequence.
abort  in  1  single-cycle pulse to return to IDLE from any state.
sw_trig  in  1  single-cycle software trigger.
trig_en  in  1  enables the level trigger.
trig_level  in  DATA_W  signed rising-crossing threshold.
cap_len  in  LEN_W  number of samples per capture; sampled when arm is accepted.
m_data  out  DATA_W  captured sample.
m_valid  out  1  output beat valid.
m_ready  in  1  downstream accept.
m_last  out  1  marks the final sample of the capture.
busy  out  1  high in ARMED and CAPTURE.
done  out  1  high in DONE.
overflow  out  1  sticky drop flag; cleared on accepted arm.
state  out  2  IDLE=0, ARMED=1, CAPTURE=2, DONE=3.

Behaviour:
Reset (rd_rst_n=0 at a rd_clk edge):
- state=IDLE; m_valid=0, m_data=0, m_last=0, overflow=0.
- Sample counter=0; prev-sample-valid=0.

Priority: abort > arm > trigger.
- abort in any state -> IDLE next cycle and clears m_valid/m_last.
- overflow is held across abort.

IDLE:
- arm with cap_len!=0 -> ARMED.
- On that transition: len_q<=cap_len, overflow<=0, prev-sample-valid<=0.
- arm with cap_len==0 is ignored.
- sw_trig is ignored.

ARMED:
- Every s_valid stores s_data into prev and sets prev-sample-valid.
- Trigger occurs in a cycle when either:
  - sw_trig=1; or
  - trig_en=1, s_valid=1, prev-sample-valid=1, signed prev<trig_level and signed s_data>=trig_level.
- On trigger -> CAPTURE.
- If s_valid is high in the trigger cycle, that sample is sample 0 and is handled per the CAPTURE rules; otherwise sample 0 is the next s_valid.
- arm in ARMED is ignored.

CAPTURE, on each counted s_valid (including one in the trigger cycle):
- If m_valid=0 or m_ready=1, the sample is loaded into m_data; m_valid<=1 next cycle (latency 1 cycle). m_last<=1 iff counter==len_q-1.
- Otherwise the sample is dropped: overflow<=1 and the output register is unchanged.
- Counter increments on every counted sample, dropped or not, so the capture window is a fixed number of ADC samples.
- When counter==len_q-1 with s_valid -> DONE; counter<=0.
- If that final sample is dropped, no beat carries m_last; overflow identifies the case.
- arm in CAPTURE is ignored.

Output handshake:
- m_data/m_last stay stable while m_valid=1 and m_ready=0.
- m_valid clears after m_ready=1 unless a new sample loads in the same cycle.
- m_valid is never set outside CAPTURE loads.

DONE:
- done=1; the pending output beat still drains normally.
- arm -> ARMED with the same latching as from IDLE, but only if m_valid=0 or m_ready=1 in that cycle; otherwise arm is ignored.
- busy=0.

Boundaries:
- cap_len=1: the trigger-cycle sample carries m_last; state goes to DONE in the same transition.
- cap_len=2^LEN_W-1 is the maximum length; the counter never wraps within a capture.
- Reset mid-capture discards any pending beat.

Test Plan:
- Single capture: arm with cap_len=4, sw_trig, then 4 s_valid samples 10,11,12,13 with m_ready=1 -> m_data 10..13 each 1 cycle after input; m_last only on 13; state ends DONE; overflow=0.
- Level trigger: trig_en=1, trig_level=100, samples 50,99,100,120 with cap_len=2 -> capture starts at 100; beats 100,120; m_last on 120. Negative case: prev=-5, sample=-3 with level=-4 -> triggers.
- Backpressure drop: cap_len=3, m_ready=0, samples 1,2,3 back-to-back -> m_data holds 1; 2 and 3 dropped; overflow=1; DONE reached; no m_last beat.
- Abort mid-capture: abort after 2 of 8 samples -> IDLE next cycle; m_valid=0; later samples ignored. Then arm plus sw_trig -> fresh capture with counter restarting at 0.
- Simultaneous events: abort together with arm in IDLE -> stays IDLE. sw_trig together with s_valid=7 in ARMED -> 7 is sample 0. cap_len=0 arm -> stays IDLE.
- Reset mid-operation: rd_rst_n low in CAPTURE with m_valid=1 -> next edge state=0, m_valid=0, m_last=0, overflow=0.
